// File: rtl/fifo_mac_pkg.sv
// Shared types and width helpers for the MAC control sequencer.
package fifo_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_seq_state_t;

  function automatic int acc_width(input int width, input int amount_of_data);
    return 32'sd2 * width + $clog2(amount_of_data);
  endfunction

  function automatic int cnt_width(input int modulo);
    return (modulo > 32'sd1) ? $clog2(modulo) : 32'sd1;
  endfunction

endpackage

// File: rtl/mac_seq_counter.sv
// Modulo up-counter with synchronous clear, enable and terminal-count flag.
module mac_seq_counter #(
  parameter int MODULO = 16,
  parameter int W      = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] TC_VAL = W'(MODULO - 1);

  logic [W-1:0] r_cnt;

  // count register: clear wins over enable, wraps after the terminal value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TC_VAL) ? '0 : r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/fifo_mac_sequencer.sv
// Joins two stream handshakes into MAC beats, frames packets and returns
// each packet's accumulated result on a valid/ready port.
module fifo_mac_sequencer
  import fifo_mac_pkg::*;
#(
  parameter  int WIDTH            = 8,
  parameter  int AMOUNT_OF_DATA   = 16,
  parameter  int AMOUNT_OF_PACKET = 4,
  parameter  int MAC_LATENCY      = 2,
  localparam int ACC_W            = acc_width(WIDTH, AMOUNT_OF_DATA),
  localparam int PKT_W            = cnt_width(AMOUNT_OF_PACKET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in1,
  output logic             ready_1,
  input  logic             valid_in2,
  output logic             ready_2,
  output logic             mac_en,
  output logic             mac_first,
  output logic             mac_last,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_o,
  output logic [PKT_W-1:0] pkt_idx,
  output logic             busy,
  output logic             done
);

  localparam int BEAT_W = cnt_width(AMOUNT_OF_DATA);
  localparam int LAT_W  = cnt_width(MAC_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MAC_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  mac_seq_state_t   r_state;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [ACC_W-1:0] r_data_o;
  logic             r_valid_o;
  logic             r_busy;
  logic             r_done;

  logic              w_run;
  logic              w_fire;
  logic              w_launch;
  logic              w_accept;
  logic [BEAT_W-1:0] w_beat_cnt;
  logic              w_beat_tc;
  logic [PKT_W-1:0]  w_pkt_cnt;
  logic              w_pkt_tc;

  assign w_run    = (r_state == RUN);
  assign w_fire   = w_run & valid_in1 & valid_in2;
  assign w_launch = (r_state == IDLE) & start;
  assign w_accept = (r_state == OUT) & r_valid_o & ready_o;

  // Each ready looks only at the other stream's valid, so no comb loop forms upstream.
  assign ready_1   = w_run & valid_in2;
  assign ready_2   = w_run & valid_in1;
  assign mac_en    = w_fire;
  assign mac_first = w_fire & (w_beat_cnt == '0);
  assign mac_last  = w_fire & w_beat_tc;

  mac_seq_counter #(.MODULO(AMOUNT_OF_DATA), .W(BEAT_W)) u_beat_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_launch),
    .i_en    (w_fire),
    .o_cnt   (w_beat_cnt),
    .o_tc    (w_beat_tc)
  );

  mac_seq_counter #(.MODULO(AMOUNT_OF_PACKET), .W(PKT_W)) u_pkt_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_launch | (w_accept & w_pkt_tc)),
    .i_en    (w_accept),
    .o_cnt   (w_pkt_cnt),
    .o_tc    (w_pkt_tc)
  );

  // sequencing FSM with registered result, status and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (w_fire && w_beat_tc) begin
            r_state   <= DRAIN;
            r_lat_cnt <= LAT_INIT;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          // lat_cnt==1 lands exactly MAC_LATENCY cycles after the mac_last beat
          if (r_lat_cnt == LAT_ONE) begin
            r_data_o  <= acc_in;
            r_valid_o <= 1'b1;
            r_lat_cnt <= '0;
            r_state   <= OUT;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_ONE;
          end
        end
        OUT: begin
          if (w_accept) begin
            r_valid_o <= 1'b0;
            if (w_pkt_tc) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_state <= OUT;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_valid_o <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pkt_idx = w_pkt_cnt;

endmodule

// File: tb/tb_fifo_mac_sequencer.sv
// Self-checking bench: a behavioural MAC datapath plus per-packet sums of products.
`timescale 1ns/1ps
module tb_fifo_mac_sequencer;

  localparam int N = 16;
  localparam int P = 4;
  localparam int M_BASIC = 0, M_STALL = 1, M_BP = 2, M_FULL = 3, M_RESET = 4, M_RAND = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, valid_in1, valid_in2, ready_1, ready_2;
  logic        mac_en, mac_first, mac_last, valid_o, ready_o, busy, done;
  logic [19:0] acc_in, data_o;
  logic [1:0]  pkt_idx;

  logic        start_b, vb1, vb2, rb1, rb2, me_b, mf_b, ml_b, vo_b, ro_b, busy_b, done_b;
  logic [16:0] acc_in_b, data_o_b;
  logic [0:0]  pkt_idx_b;

  int checks = 0;
  int errors = 0;

  int unsigned q1[$];
  int unsigned q2[$];
  logic [31:0] acc_m, acc_d, acc_mb;
  logic        cap_en, cap_first, cap_en_b, cap_first_b;

  fifo_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .valid_in1(valid_in1), .ready_1(ready_1), .valid_in2(valid_in2), .ready_2(ready_2),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last), .acc_in(acc_in),
    .data_o(data_o), .valid_o(valid_o), .ready_o(ready_o),
    .pkt_idx(pkt_idx), .busy(busy), .done(done)
  );

  fifo_mac_sequencer #(.WIDTH(8), .AMOUNT_OF_DATA(2), .AMOUNT_OF_PACKET(1), .MAC_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .valid_in1(vb1), .ready_1(rb1), .valid_in2(vb2), .ready_2(rb2),
    .mac_en(me_b), .mac_first(mf_b), .mac_last(ml_b), .acc_in(acc_in_b),
    .data_o(data_o_b), .valid_o(vo_b), .ready_o(ro_b),
    .pkt_idx(pkt_idx_b), .busy(busy_b), .done(done_b)
  );

  // datapath model: controls captured mid-cycle, applied on the closing edge
  always @(negedge clk) begin
    cap_en      <= mac_en;
    cap_first   <= mac_first;
    cap_en_b    <= me_b;
    cap_first_b <= mf_b;
  end

  // stream heads feed the multiplier; one extra stage gives a latency of 2
  always @(posedge clk) begin
    if (cap_en && q1.size() != 0 && q2.size() != 0) begin
      acc_m <= (cap_first ? 32'd0 : acc_m) + q1[0] * q2[0];
      void'(q1.pop_front());
      void'(q2.pop_front());
    end
    acc_d <= acc_m;
    if (cap_en_b) acc_mb <= (cap_first_b ? 32'd0 : acc_mb) + 32'd35;
  end

  assign acc_in   = acc_d[19:0];
  assign acc_in_b = acc_mb[16:0];

  task automatic run_job(input int mode);
    int          pkt, beat, cyc, last_cyc, run_cyc, bp_cnt;
    bit          in_run, fin, fire, exp_valid;
    int unsigned pa, pb, sum;
    int unsigned exp_data[P];
    for (int p = 0; p < P; p++) begin
      sum = 0;
      for (int k = 0; k < N; k++) begin
        case (mode)
          M_FULL:  begin pa = 2; pb = 3; end
          M_RAND:  begin pa = $urandom_range(255); pb = $urandom_range(255); end
          default: begin pa = k + 1; pb = k + 1; end
        endcase
        q1.push_back(pa);
        q2.push_back(pb);
        sum += pa * pb;
      end
      exp_data[p] = sum;
    end
    start = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1; ready_o = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, mac_en, ready_1} !== 3'b000) begin
      errors++; $display("FAIL launch_idle got %b exp 000", {busy, mac_en, ready_1});
    end
    @(posedge clk); #1;
    start = 1'b0;
    pkt = 0; beat = 0; cyc = 0; last_cyc = -100; run_cyc = 0; bp_cnt = 0;
    in_run = 1'b1; fin = 1'b0;
    while (!fin) begin
      if (cyc > 1500) begin
        errors++; $display("FAIL job_timeout got %0d cycles exp <=1500", cyc);
        return;
      end
      if (mode == M_RESET && !in_run && cyc == last_cyc + 1) begin
        rst = 1'b0; #1;
        checks++;
        if ({ready_1, ready_2, mac_en, mac_first, mac_last, valid_o, busy, done, pkt_idx, data_o} !== 30'd0) begin
          errors++; $display("FAIL reset_drain_outputs got %0h exp 0",
                             {ready_1, ready_2, mac_en, mac_first, mac_last, valid_o, busy, done, pkt_idx, data_o});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      valid_in1 = 1'b1; valid_in2 = 1'b1; ready_o = 1'b1;
      case (mode)
        M_STALL: valid_in2 = (run_cyc % 2) == 1;
        M_BP:    ready_o = (bp_cnt >= 5);
        M_RAND:  begin
          valid_in1 = 1'($urandom_range(1)); valid_in2 = 1'($urandom_range(1)); ready_o = 1'($urandom_range(1));
        end
        M_FULL:  start = (pkt == 1 && beat == 5);
        default: ready_o = 1'b1;
      endcase
      @(negedge clk);
      fire = in_run & valid_in1 & valid_in2;
      exp_valid = !in_run && (cyc >= last_cyc + 3);
      checks++;
      if ({ready_1, ready_2, mac_en} !== {in_run & valid_in2, in_run & valid_in1, fire}) begin
        errors++; $display("FAIL handshake cyc %0d got %b exp %b", cyc, {ready_1, ready_2, mac_en},
                           {in_run & valid_in2, in_run & valid_in1, fire});
      end
      checks++;
      if ({mac_first, mac_last} !== {fire && beat == 0, fire && beat == N - 1}) begin
        errors++; $display("FAIL framing beat %0d got %b exp %b", beat, {mac_first, mac_last},
                           {fire && beat == 0, fire && beat == N - 1});
      end
      checks++;
      if ({busy, done, pkt_idx} !== {1'b1, 1'b0, 2'(pkt)}) begin
        errors++; $display("FAIL status cyc %0d got %b exp %b", cyc, {busy, done, pkt_idx}, {1'b1, 1'b0, 2'(pkt)});
      end
      checks++;
      if (valid_o !== exp_valid) begin
        errors++; $display("FAIL valid_o cyc %0d got %b exp %b", cyc, valid_o, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (data_o !== 20'(exp_data[pkt])) begin
          errors++; $display("FAIL data_o pkt %0d got %0d exp %0d", pkt, data_o, exp_data[pkt]);
        end
      end
      if (in_run) run_cyc++;
      if (fire) begin
        beat++;
        if (beat == N) begin
          beat = 0; in_run = 1'b0; last_cyc = cyc;
          if (mode == M_STALL) begin
            checks++;
            if (run_cyc != 32) begin
              errors++; $display("FAIL stall_packet_len got %0d exp 32", run_cyc);
            end
          end
        end
      end
      if (exp_valid && ready_o) begin
        bp_cnt = 0;
        if (pkt == P - 1) fin = 1'b1;
        else begin pkt++; in_run = 1'b1; run_cyc = 0; end
      end else if (exp_valid) begin
        bp_cnt++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    valid_in1 = 1'b0; valid_in2 = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy, valid_o} !== 3'b100) begin
      errors++; $display("FAIL done_pulse got %b exp 100", {done, busy, valid_o});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done, busy, pkt_idx} !== 4'b0000) begin
      errors++; $display("FAIL after_done got %b exp 0000", {done, busy, pkt_idx});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_1, ready_2, mac_en, mac_first, mac_last, valid_o, busy, done, pkt_idx, data_o} !== 30'd0) begin
      errors++; $display("FAIL reset_a got %0h exp 0", {valid_o, busy, done, pkt_idx, data_o});
    end
    checks++;
    if ({rb1, rb2, me_b, mf_b, ml_b, vo_b, busy_b, done_b, pkt_idx_b, data_o_b} !== 26'd0) begin
      errors++; $display("FAIL reset_b got %0h exp 0", {vo_b, busy_b, done_b, pkt_idx_b, data_o_b});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, valid_o, done} !== 3'b000) begin
      errors++; $display("FAIL reset_release got %b exp 000", {busy, valid_o, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();        run_job(M_BASIC); endtask
  task automatic test_stream_stall(); run_job(M_STALL); endtask
  task automatic test_backpressure(); run_job(M_BP);    endtask
  task automatic test_full_job();     run_job(M_FULL);  endtask

  task automatic test_reset_mid_drain();
    run_job(M_RESET);
    q1.delete();
    q2.delete();
    @(negedge clk);
    checks++;
    if ({busy, valid_o, pkt_idx} !== 4'b0000) begin
      errors++; $display("FAIL post_reset_idle got %b exp 0000", {busy, valid_o, pkt_idx});
    end
    @(posedge clk); #1;
    run_job(M_BASIC);
  endtask

  task automatic test_random();
    repeat (2) run_job(M_RAND);
  endtask

  task automatic test_edge_params();
    start_b = 1'b1; vb1 = 1'b1; vb2 = 1'b1; ro_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_b, me_b} !== 2'b00) begin
      errors++; $display("FAIL edge_idle got %b exp 00", {busy_b, me_b});
    end
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({me_b, mf_b, ml_b, rb1, rb2, busy_b} !== 6'b110111) begin
      errors++; $display("FAIL edge_beat0 got %b exp 110111", {me_b, mf_b, ml_b, rb1, rb2, busy_b});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({me_b, mf_b, ml_b} !== 3'b101) begin
      errors++; $display("FAIL edge_beat1 got %b exp 101", {me_b, mf_b, ml_b});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({me_b, vo_b, rb1, rb2} !== 4'b0000) begin
      errors++; $display("FAIL edge_drain got %b exp 0000", {me_b, vo_b, rb1, rb2});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({vo_b, busy_b, data_o_b} !== {2'b11, 17'd70}) begin
      errors++; $display("FAIL edge_result got v%b b%b %0d exp v1 b1 70", vo_b, busy_b, data_o_b);
    end
    @(posedge clk); #1;
    vb1 = 1'b0; vb2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_b, busy_b, vo_b} !== 3'b100) begin
      errors++; $display("FAIL edge_done got %b exp 100", {done_b, busy_b, vo_b});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done_b !== 1'b0) begin
      errors++; $display("FAIL edge_done_width got %b exp 0", done_b);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; ready_o = 1'b0;
    start_b = 1'b0; vb1 = 1'b0; vb2 = 1'b0; ro_b = 1'b0;
    test_reset();
    test_basic();
    test_stream_stall();
    test_backpressure();
    test_full_job();
    test_reset_mid_drain();
    test_random();
    test_edge_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
